dmem_arbiter: RTL and testbench

//  Shares the single-port 256x32 data RAM between the CPU load/store port (P0) and the

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_rr_pick2.sv | 40 ++++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding and port indices.
package dmem_arbiter_pkg;

   // Port currently holding a burst of grants.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_e;

   // Port indices; also the encoding of the "last port served" register.
   localparam logic P0_IDX = 1'b0;
   localparam logic P1_IDX = 1'b1;

   // Owner value corresponding to a port index.
   function automatic owner_e own_of(input logic idx);
      return (idx == P1_IDX) ? OWN_P1 : OWN_P0;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick with a burst limit.
//  req       in   2    request vector {p1, p0}
//  owner     in   2    port holding the current burst
//  last      in   1    last port served (0 = P0, 1 = P1)
//  count     in   CW   grants given to owner in the current burst
//  gnt_c     out  2    one-hot (or zero) grant vector {p1, p0}
module rr_pick2
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned CW        = 3
) (
   input  logic [1:0]    req,
   input  owner_e        owner,
   input  logic          last,
   input  logic [CW-1:0] count,
   output logic [1:0]    gnt_c
);

   logic burst_done;

   // Contention is resolved by the burst owner until its limit, else by last-served.
   always_comb begin
      gnt_c      = 2'b00;
      burst_done = (count >= CW'(MAX_BURST));
      case (req)
         2'b01: gnt_c = 2'b01;
         2'b10: gnt_c = 2'b10;
         2'b11: begin
            case (owner)
               OWN_P0:  gnt_c = burst_done ? 2'b10 : 2'b01;
               OWN_P1:  gnt_c = burst_done ? 2'b01 : 2'b10;
               default: gnt_c = (last == P1_IDX) ? 2'b01 : 2'b10;
            endcase
         end
         default: gnt_c = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data RAM between the CPU port (P0) and the debug/loader port (P1).
// One access per cycle, round-robin with a burst limit; read data returns one cycle after grant.
//  CLOCK_50            in   clock
//  reset               in   synchronous active-high reset
//  pX_req/we/addr/wdata in  port request, write flag, word address, write data
//  pX_gnt              out  access issued this cycle (combinational)
//  p0_stall            out  CPU request pending without grant (combinational)
//  pX_rvalid/rdata     out  read return, one cycle after a read grant
//  ram_addr/data/wren  out  RAM request of the granted port (combinational)
//  ram_q               in   RAM read data, one cycle after address
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned AW        = 8,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic          p0_gnt,
   output logic          p0_stall,
   output logic          p0_rvalid,
   output logic [DW-1:0] p0_rdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic          p1_gnt,
   output logic          p1_rvalid,
   output logic [DW-1:0] p1_rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_data,
   output logic          ram_wren,
   input  logic [DW-1:0] ram_q
);

   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   owner_e        owner_q, owner_d;
   logic          last_q, last_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    rd_pend_q, rd_pend_d;
   logic [DW-1:0] p0_rdata_q, p0_rdata_d;
   logic [DW-1:0] p1_rdata_q, p1_rdata_d;
   logic [1:0]    gnt_c;
   logic          sel;

   rr_pick2 #(
      .MAX_BURST (MAX_BURST),
      .CW        (CW)
   ) u_pick (
      .req   ({p1_req, p0_req}),
      .owner (owner_q),
      .last  (last_q),
      .count (count_q),
      .gnt_c (gnt_c)
   );

   // Grant, stall and RAM request mux.
   always_comb begin
      ram_addr = '0;
      ram_data = '0;
      ram_wren = 1'b0;
      p0_gnt   = gnt_c[0];
      p1_gnt   = gnt_c[1];
      p0_stall = p0_req & ~gnt_c[0];
      if (gnt_c[0]) begin
         ram_addr = p0_addr;
         ram_data = p0_wdata;
         ram_wren = p0_we & ~reset;
      end else if (gnt_c[1]) begin
         ram_addr = p1_addr;
         ram_data = p1_wdata;
         ram_wren = p1_we & ~reset;
      end
   end

   // Read return: a pending read is cancelled by reset in its return cycle.
   always_comb begin
      p0_rvalid  = rd_pend_q[0] & ~reset;
      p1_rvalid  = rd_pend_q[1] & ~reset;
      p0_rdata   = p0_rvalid ? ram_q : p0_rdata_q;
      p1_rdata   = p1_rvalid ? ram_q : p1_rdata_q;
      p0_rdata_d = p0_rdata;
      p1_rdata_d = p1_rdata;
   end

   // Arbiter next state: burst tracking and read-pending flags.
   always_comb begin
      owner_d   = owner_q;
      last_d    = last_q;
      count_d   = count_q;
      sel       = gnt_c[1];
      rd_pend_d = {gnt_c[1] & ~p1_we, gnt_c[0] & ~p0_we};
      if (gnt_c != 2'b00) begin
         if (owner_q == own_of(sel)) begin
            // Saturate so an uncontended port can keep going without wrapping.
            if (count_q < CW'(MAX_BURST)) begin
               count_d = count_q + CW'(1);
            end
         end else begin
            owner_d = own_of(sel);
            count_d = CW'(1);
         end
         last_d = sel;
      end else begin
         owner_d = OWN_NONE;
         count_d = '0;
      end
   end

   // State registers.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         owner_q    <= OWN_NONE;
         last_q     <= P1_IDX;
         count_q    <= '0;
         rd_pend_q  <= '0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
      end else begin
         owner_q    <= owner_d;
         last_q     <= last_d;
         count_q    <= count_d;
         rd_pend_q  <= rd_pend_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x32 RAM and a read-data scoreboard.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [7:0]  p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata;
   logic        p0_gnt, p0_stall, p0_rvalid, p1_gnt, p1_rvalid;
   logic [31:0] p0_rdata, p1_rdata;
   logic [7:0]  ram_addr;
   logic [31:0] ram_data, ram_q;
   logic        ram_wren;

   logic [31:0] mem       [0:255];
   logic [31:0] model_mem [0:255];
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];
   logic        pend0, pend1;
   int          n_cmp;
   int          n_bad;

   dmem_arbiter #(
      .AW(8), .DW(32), .MAX_BURST(4)
   ) dut (
      .CLOCK_50  (clk),
      .reset     (reset),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_gnt    (p0_gnt),
      .p0_stall  (p0_stall),
      .p0_rvalid (p0_rvalid),
      .p0_rdata  (p0_rdata),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .p1_rdata  (p1_rdata),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_wren  (ram_wren),
      .ram_q     (ram_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous single-port RAM: read data one cycle after address.
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   function automatic logic [31:0] init_val(input int i);
      if (i == 16) return 32'hDEADBEEF;
      return {8'hA5, 8'(i), 8'(~i), 8'h3C};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock cycle: check grants/stall/wren and read returns, then score this cycle's reads.
   task automatic cyc(input string tag, input logic eg0, input logic eg1, input logic ewren);
      logic [31:0] e;
      @(negedge clk);
      chk({tag, ":p0_gnt"}, 32'(p0_gnt), 32'(eg0));
      chk({tag, ":p1_gnt"}, 32'(p1_gnt), 32'(eg1));
      chk({tag, ":p0_stall"}, 32'(p0_stall), 32'(p0_req & ~eg0));
      chk({tag, ":ram_wren"}, 32'(ram_wren), 32'(ewren));
      chk({tag, ":p0_rvalid"}, 32'(p0_rvalid), 32'(pend0));
      chk({tag, ":p1_rvalid"}, 32'(p1_rvalid), 32'(pend1));
      if (pend0) begin
         e = exp_q0.pop_front();
         chk({tag, ":p0_rdata"}, p0_rdata, e);
      end
      if (pend1) begin
         e = exp_q1.pop_front();
         chk({tag, ":p1_rdata"}, p1_rdata, e);
      end
      pend0 = eg0 & ~p0_we;
      pend1 = eg1 & ~p1_we;
      if (pend0) exp_q0.push_back(model_mem[p0_addr]);
      if (pend1) exp_q1.push_back(model_mem[p1_addr]);
      if (eg0 && p0_we) model_mem[p0_addr] = p0_wdata;
      if (eg1 && p1_we) model_mem[p1_addr] = p1_wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic rst(input int n);
      reset  = 1'b1;
      p0_req = 1'b0;
      p1_req = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("rst:p0_rvalid", 32'(p0_rvalid), 32'd0);
         chk("rst:p1_rvalid", 32'(p1_rvalid), 32'd0);
         chk("rst:ram_wren", 32'(ram_wren), 32'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      pend0 = 1'b0;
      pend1 = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
      chk("rst:p0_rdata", p0_rdata, 32'd0);
      chk("rst:p1_rdata", p1_rdata, 32'd0);
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      pend0    = 1'b0;
      pend1    = 1'b0;
      reset    = 1'b1;
      p0_req   = 1'b0;
      p0_we    = 1'b0;
      p0_addr  = '0;
      p0_wdata = '0;
      p1_req   = 1'b0;
      p1_we    = 1'b0;
      p1_addr  = '0;
      p1_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]       <= init_val(i);
         model_mem[i]  = init_val(i);
      end
      @(posedge clk);
      #1;
      rst(2);

      // 1: single P0 read of the preloaded word.
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
      cyc("t1_rd", 1'b1, 1'b0, 1'b0);
      p0_req = 1'b0;
      cyc("t1_ret", 1'b0, 1'b0, 1'b0);

      // 2: P1 write, then P0 reads it back.
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h05; p1_wdata = 32'h12345678;
      cyc("t2_wr", 1'b0, 1'b1, 1'b1);
      p1_req = 1'b0; p1_we = 1'b0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h05;
      cyc("t2_rd", 1'b1, 1'b0, 1'b0);
      p0_req = 1'b0;
      cyc("t2_ret", 1'b0, 1'b0, 1'b0);
      chk("t2_rdata_hold", p0_rdata, 32'h12345678);

      // 4: idle with last=P0, then simultaneous requests: P1 burst of 4 first.
      p0_req = 1'b1; p0_addr = 8'h20;
      p1_req = 1'b1; p1_addr = 8'h30;
      for (int i = 0; i < 9; i++) begin
         cyc("t4_cont", (i >= 4 && i < 8), (i < 4 || i == 8), 1'b0);
      end
      p0_req = 1'b0; p1_req = 1'b0;
      cyc("t4_idle", 1'b0, 1'b0, 1'b0);

      // 3: contention from reset, MAX_BURST=4: P0x4, P1x4, P0x4.
      rst(1);
      p0_req = 1'b1; p0_addr = 8'h21;
      p1_req = 1'b1; p1_addr = 8'h31;
      for (int i = 0; i < 12; i++) begin
         cyc("t3_cont", ((i / 4) % 2) == 0, ((i / 4) % 2) == 1, 1'b0);
      end
      p0_req = 1'b0; p1_req = 1'b0;
      cyc("t3_idle", 1'b0, 1'b0, 1'b0);

      // 5: reset in the return cycle of a P0 read cancels rvalid; P0 wins the first tie afterwards.
      p0_req = 1'b1; p0_addr = 8'h10;
      cyc("t5_rd", 1'b1, 1'b0, 1'b0);
      rst(1);
      p0_req = 1'b1; p0_addr = 8'h11;
      p1_req = 1'b1; p1_addr = 8'h12;
      cyc("t5_tie", 1'b1, 1'b0, 1'b0);
      p0_req = 1'b0;
      cyc("t5_p1", 1'b0, 1'b1, 1'b0);
      p1_req = 1'b0;
      cyc("t5_idle", 1'b0, 1'b0, 1'b0);

      // 6: P1 alone, 10 back-to-back reads at changing addresses.
      p1_req = 1'b1; p1_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         p1_addr = 8'(8'h40 + i);
         cyc("t6_rd", 1'b0, 1'b1, 1'b0);
      end
      p1_req = 1'b0;
      cyc("t6_idle", 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
